// File: rtl/read_channel_native_pkg.sv
// Shared types and width helpers for the native-port line-refill reader.
// Both the interface and the reader derive their widths from these functions.
package read_channel_native_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int beByteW(input int beDataW);
        return $clog2(beDataW / 8);
    endfunction

    // Back-end words per line is the front-end line size divided by the width ratio.
    function automatic int line2MemW(input int wordOffW, input int feDataW, input int beDataW);
        return wordOffW - $clog2(beDataW / feDataW);
    endfunction

    function automatic int readAddrW(input int l2m);
        return (l2m > 0) ? l2m : 1;
    endfunction

endpackage

// File: rtl/read_channel_native_if.sv
// Refill request / cache data write / back-end read port bundle.
// The master modport is the reader; the slave modport is its environment.
interface read_channel_native_if
    import read_channel_native_pkg::*;
#(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_ADDR_W  = FE_ADDR_W,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int WORD_OFF_W = 3
) ();

    localparam int BE_BYTE_W  = beByteW(BE_DATA_W);
    localparam int LINE2MEM_W = line2MemW(WORD_OFF_W, FE_DATA_W, BE_DATA_W);
    localparam int RADDR_W    = readAddrW(LINE2MEM_W);
    localparam int LINE_W     = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;

    logic                 replace_valid;
    logic [LINE_W-1:0]    replace_addr;
    logic                 replace;
    logic                 read_valid;
    logic [RADDR_W-1:0]   read_addr;
    logic [BE_DATA_W-1:0] read_data;
    logic [BE_ADDR_W-1:0] mem_addr;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [BE_DATA_W-1:0] mem_rdata;

    modport master (
        input  replace_valid, replace_addr, mem_ready, mem_rdata,
        output replace, read_valid, read_addr, read_data, mem_addr, mem_valid
    );

    modport slave (
        output replace_valid, replace_addr, mem_ready, mem_rdata,
        input  replace, read_valid, read_addr, read_data, mem_addr, mem_valid
    );

endinterface

// File: rtl/read_channel_native.sv
// Line-refill reader: fetches one cache line from the back-end native port as a
// burst of back-end words and forwards each word, with its index, to the cache.
module read_channel_native
    import read_channel_native_pkg::*;
#(
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int BE_ADDR_W  = FE_ADDR_W,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int WORD_OFF_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    read_channel_native_if.master bus
);

    localparam int BE_BYTE_W  = beByteW(BE_DATA_W);
    localparam int LINE2MEM_W = line2MemW(WORD_OFF_W, FE_DATA_W, BE_DATA_W);
    localparam int RADDR_W    = readAddrW(LINE2MEM_W);
    localparam int LINE_W     = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;

    state_t               r_state;
    state_t               w_nextState;
    logic [LINE_W-1:0]    r_lineAddr;
    logic                 w_accept;
    logic                 w_transfer;
    logic                 w_lastWord;
    logic                 w_replace;
    logic                 w_memValid;
    logic [FE_ADDR_W-1:0] w_fullAddr;
    logic [RADDR_W-1:0]   w_readAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // READ holds until the last word of the line is accepted by the back end.
    always_comb begin
        w_nextState = r_state;
        w_replace   = 1'b0;
        w_memValid  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.replace_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = READ;
                end
            end
            READ: begin
                w_replace  = 1'b1;
                w_memValid = 1'b1;
                if (bus.mem_ready && w_lastWord) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_replace   = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_transfer = w_memValid & bus.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lineAddr <= '0;
        end else if (w_accept) begin
            r_lineAddr <= bus.replace_addr;
        end
    end

    // A single-word line needs no burst counter; the only word is also the last.
    generate
        if (LINE2MEM_W > 0) begin : g_burst
            logic [LINE2MEM_W-1:0] r_wordCnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wordCnt <= '0;
                end else if (w_accept) begin
                    r_wordCnt <= '0;
                end else if (w_transfer && !w_lastWord) begin
                    r_wordCnt <= r_wordCnt + 1'b1;
                end
            end

            assign w_lastWord = &r_wordCnt;
            assign w_readAddr = r_wordCnt;
            assign w_fullAddr = {r_lineAddr, r_wordCnt, {BE_BYTE_W{1'b0}}};
        end else begin : g_single
            assign w_lastWord = 1'b1;
            assign w_readAddr = '0;
            assign w_fullAddr = {r_lineAddr, {BE_BYTE_W{1'b0}}};
        end
    endgenerate

    assign bus.replace    = w_replace;
    assign bus.mem_valid  = w_memValid;
    assign bus.mem_addr   = BE_ADDR_W'(w_fullAddr);
    assign bus.read_valid = w_transfer;
    assign bus.read_addr  = w_readAddr;
    assign bus.read_data  = bus.mem_rdata;

endmodule
